mole_hit_scorer: RTL

- Sits directly downstream of the mole position generator.
- Consumes the current mole hole index and its change strobe, plus five debounced player buttons.
- Decides hit, miss or escape; keeps a saturating score and miss count.
- Drives the change-position request back upstream on every hit; freezes the game once the miss limit is reached.

---
 rtl/mole_pkg.sv | 18 +
 rtl/button_edge_detect.sv | 20 ++
 rtl/mole_hit_scorer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: shared state encoding and constants for the mole hit scorer.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      HIT_WAIT,
      GAME_OVER
   } state_t;

   localparam logic [2:0] NO_MOLE       = 3'd5;
   localparam int         NUM_HOLES_DEF = 5;

   function automatic logic pos_valid(input logic [2:0] pos, input int holes);
      return {29'd0, pos} < holes;
   endfunction

endpackage

// File: rtl/button_edge_detect.sv
// button_edge_detect: registers the button levels and flags rising edges.
module button_edge_detect #(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] buttons,
   output logic [N-1:0] press
);

   logic [N-1:0] prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= '0;
      else     prev <= buttons;
   end

   assign press = buttons & ~prev;

endmodule

// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: judges presses against the mole, keeps score and misses.
// Macro MOLE_STREAK_BONUS_EN adds a hit streak counter and bonus scoring.
module mole_hit_scorer
   import mole_pkg::*;
#(
   parameter int NUM_HOLES  = NUM_HOLES_DEF,
   parameter int SCORE_W    = 8,
   parameter int MAX_MISSES = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [2:0]           i_mole_position,
   input  logic                 i_position_changed,
   input  logic [NUM_HOLES-1:0] i_buttons,
   output logic                 o_change_position,
   output logic                 o_hit,
   output logic                 o_miss,
   output logic [SCORE_W-1:0]   o_score,
   output logic [2:0]           o_misses,
   output logic                 o_game_over
`ifdef MOLE_STREAK_BONUS_EN
   ,
   output logic [2:0]           o_streak
`endif
);

   localparam logic [2:0] MISS_LIMIT = 3'(MAX_MISSES);

   state_t               state;
   logic [2:0]           target;
   logic [NUM_HOLES-1:0] press;
   logic [NUM_HOLES-1:0] onehot;
   logic                 new_valid;
   logic                 hit_ev;
   logic                 miss_ev;
   logic [1:0]           inc;
   logic [SCORE_W:0]     sum;
   logic [SCORE_W-1:0]   score_nxt;
   logic [2:0]           misses_nxt;

   button_edge_detect #(.N(NUM_HOLES)) u_edge (
      .clk     (i_clk),
      .rst     (i_rst),
      .buttons (i_buttons),
      .press   (press)
   );

`ifdef MOLE_STREAK_BONUS_EN
   logic [2:0] streak;
   assign o_streak = streak;
   assign inc      = (streak >= 3'd3) ? 2'd2 : 2'd1;
`else
   assign inc      = 2'd1;
`endif

   // target still holds the mole the player saw; the strobe loads it afterwards
   assign new_valid  = pos_valid(i_mole_position, NUM_HOLES);
   assign onehot     = NUM_HOLES'(1) << target;
   assign hit_ev     = (state == ARMED) && (press != '0) && (press == onehot);
   assign miss_ev    = (state == ARMED) && !hit_ev
                       && ((press != '0) || i_position_changed);
   assign sum        = {1'b0, o_score} + {{(SCORE_W-1){1'b0}}, inc};
   assign score_nxt  = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
   assign misses_nxt = (o_misses >= MISS_LIMIT) ? MISS_LIMIT : o_misses + 3'd1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state             <= IDLE;
         target            <= NO_MOLE;
         o_change_position <= 1'b0;
         o_hit             <= 1'b0;
         o_miss            <= 1'b0;
         o_score           <= '0;
         o_misses          <= '0;
         o_game_over       <= 1'b0;
`ifdef MOLE_STREAK_BONUS_EN
         streak            <= '0;
`endif
      end else begin
         o_change_position <= 1'b0;
         o_hit             <= 1'b0;
         o_miss            <= 1'b0;
         if (i_position_changed) target <= i_mole_position;
         unique case (state)
            IDLE: begin
               if (i_position_changed && new_valid) state <= ARMED;
            end
            ARMED: begin
               if (hit_ev) begin
                  o_hit             <= 1'b1;
                  o_change_position <= 1'b1;
                  o_score           <= score_nxt;
                  state             <= HIT_WAIT;
`ifdef MOLE_STREAK_BONUS_EN
                  if (streak != 3'd7) streak <= streak + 3'd1;
`endif
               end else if (miss_ev) begin
                  o_miss   <= 1'b1;
                  o_misses <= misses_nxt;
`ifdef MOLE_STREAK_BONUS_EN
                  streak   <= '0;
`endif
                  if (misses_nxt == MISS_LIMIT) begin
                     o_game_over <= 1'b1;
                     state       <= GAME_OVER;
                  end else if (i_position_changed) begin
                     state <= new_valid ? ARMED : IDLE;
                  end
               end
            end
            HIT_WAIT: begin
               if (i_position_changed) state <= new_valid ? ARMED : IDLE;
            end
            GAME_OVER: begin
               state <= GAME_OVER;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
